// File: rtl/bin2gray_counter_pkg.sv
// Shared definitions for the binary/Gray counter and its decoder-side users.
package bin2gray_counter_pkg;

  // Width the counter is normally built at.
  localparam int unsigned DEFAULT_WIDTH = 4;

  // All-ones count for the default width.
  localparam logic [DEFAULT_WIDTH-1:0] MAX = '1;

  // The helpers below work on a 32-bit word.
  // Any narrower code is zero-extended by the caller.
  // Leading zeros do not disturb either transform.
  localparam int unsigned WORD = 32;

  // Per-edge action chosen by the counter's next-state mux.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_INC  = 2'd2,
    ACT_DEC  = 2'd3
  } step_t;

  // Binary to Gray: G = B ^ (B >> 1).
  function automatic logic [WORD-1:0] bin2gray(input logic [WORD-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WORD-1:0] gray2bin(input logic [WORD-1:0] g);
    logic [WORD-1:0] b;
    b = '0;
    b[WORD-1] = g[WORD-1];
    for (int unsigned i = WORD - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin2gray_counter_enc.sv
// Combinational WIDTH-bit binary to Gray encoder.
// It feeds the gray_out register.
module bin2gray_enc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Each Gray bit is the XOR of a binary bit with its upper neighbour.
  always_comb begin
    gray = bin ^ (bin >> 1);
  end

endmodule

// File: rtl/bin2gray_counter.sv
// Registered binary/Gray up-down counter.
// Both the binary count and its Gray code come straight from flops.
// This keeps the Gray output glitch-free for clock-domain crossings.
module bin2gray_counter
  import bin2gray_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  step_t            act;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;

  // Pick this edge's action: load beats counting, counting beats hold.
  always_comb begin
    act = ACT_HOLD;
    if (load) begin
      act = ACT_LOAD;
    end else if (en) begin
      act = up ? ACT_INC : ACT_DEC;
    end
  end

  // Next binary count and wrap pulse.
  // At a limit the count either wraps or saturates.
  always_comb begin
    bin_next  = bin_out;
    wrap_next = 1'b0;
    unique case (act)
      ACT_LOAD: bin_next = load_bin;
      ACT_INC: begin
        if (bin_out == CNT_MAX) begin
          if (WRAP != 0) begin
            bin_next  = '0;
            wrap_next = 1'b1;
          end
        end else begin
          bin_next = bin_out + WIDTH'(1);
        end
      end
      ACT_DEC: begin
        if (bin_out == '0) begin
          if (WRAP != 0) begin
            bin_next  = CNT_MAX;
            wrap_next = 1'b1;
          end
        end else begin
          bin_next = bin_out - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Encoding the next-state binary lets gray_out be registered on the same edge.
  // That keeps gray_out == enc(bin_out) on every cycle.
  bin2gray_enc #(
    .WIDTH(WIDTH)
  ) u_enc (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // Limit flag for the currently selected direction.
  always_comb begin
    at_limit = up ? (bin_out == CNT_MAX) : (bin_out == '0);
  end

  // Output registers: asynchronous clear, synchronous update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= '0;
      gray_out <= '0;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= bin_next;
      gray_out <= gray_next;
      wrap     <= wrap_next;
    end
  end

endmodule

// File: tb/tb_bin2gray_counter.sv
// Self-checking bench for bin2gray_counter.
// Two instances share one set of inputs: one wraps, one saturates.
module tb_bin2gray_counter;
  import bin2gray_counter_pkg::*;

  localparam int W = 4;
  localparam int M = int'(MAX);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] bin_w, gray_w, bin_s, gray_s;
  logic         wrap_w, lim_w, wrap_s, lim_s;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_w    = 0;
  int cnt_s    = 0;

  always #5 clk = ~clk;

  bin2gray_counter #(.WIDTH(W), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .bin_out(bin_w), .gray_out(gray_w), .wrap(wrap_w), .at_limit(lim_w)
  );

  bin2gray_counter #(.WIDTH(W), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .bin_out(bin_s), .gray_out(gray_s), .wrap(wrap_s), .at_limit(lim_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference behaviour: one counting step on an integer count.
  function automatic int model_next(input int c, input bit l, input int lb, input bit e,
                                    input bit u, input bit wrapm, output bit w);
    w = 1'b0;
    if (l) return lb;
    if (!e) return c;
    if (u) begin
      if (c < M) return c + 1;
      if (wrapm) begin w = 1'b1; return 0; end
      return M;
    end
    if (c > 0) return c - 1;
    if (wrapm) begin w = 1'b1; return M; end
    return 0;
  endfunction

  // Apply one cycle of inputs, clock it, and check both instances.
  task automatic step(input bit e, input bit u, input bit l, input int lb);
    int  nw, ns;
    bit  ew, es;
    logic [31:0] old_gw, old_gs;
    en = e; up = u; load = l; load_bin = W'(lb);
    nw = model_next(cnt_w, l, lb, e, u, 1'b1, ew);
    ns = model_next(cnt_s, l, lb, e, u, 1'b0, es);
    old_gw = bin2gray(32'(cnt_w));
    old_gs = bin2gray(32'(cnt_s));
    @(posedge clk); #1;
    chk("bin_w",  32'(bin_w),  32'(nw));
    chk("gray_w", 32'(gray_w), bin2gray(32'(nw)));
    chk("dec_w",  gray2bin(32'(gray_w)), 32'(nw));
    chk("wrap_w", 32'(wrap_w), 32'(ew));
    chk("lim_w",  32'(lim_w),  32'(u ? (nw == M) : (nw == 0)));
    chk("bin_s",  32'(bin_s),  32'(ns));
    chk("gray_s", 32'(gray_s), bin2gray(32'(ns)));
    chk("wrap_s", 32'(wrap_s), 32'(es));
    chk("lim_s",  32'(lim_s),  32'(u ? (ns == M) : (ns == 0)));
    if (!l && nw != cnt_w) chk("ham_w", 32'($countones(32'(gray_w) ^ old_gw)), 32'd1);
    if (!l && ns != cnt_s) chk("ham_s", 32'($countones(32'(gray_s) ^ old_gs)), 32'd1);
    if (!l && ns == cnt_s) chk("hold_s", 32'(gray_s), old_gs);
    cnt_w = nw;
    cnt_s = ns;
  endtask

  logic [3:0] gtab [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                            4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst_bin",  32'(bin_w),  32'd0);
    chk("rst_gray", 32'(gray_w), 32'd0);
    chk("rst_wrap", 32'(wrap_w), 32'd0);
    chk("gtab0",    32'(gray_w), 32'(gtab[0]));

    // Full up-count sequence against the literal Gray table.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 1'b0, 0);
      chk("gtab", 32'(gray_w), 32'(gtab[i]));
      chk("gtab_wrap", 32'(wrap_w), 32'(i == 16));
    end

    // Load wins over a simultaneous increment.
    step(1'b1, 1'b1, 1'b1, 5);
    chk("load_bin",  32'(bin_w),  32'd5);
    chk("load_gray", 32'(gray_w), 32'b0111);

    // Decrement from zero: wrap vs saturate.
    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("dn_bin_w",  32'(bin_w),  32'd15);
    chk("dn_gray_w", 32'(gray_w), 32'b1000);
    chk("dn_wrap_w", 32'(wrap_w), 32'd1);
    chk("dn_bin_s",  32'(bin_s),  32'd0);
    chk("dn_wrap_s", 32'(wrap_s), 32'd0);
    chk("dn_lim_s",  32'(lim_s),  32'd1);

    // Count to 9, then reset between edges.
    step(1'b0, 1'b1, 1'b1, 0);
    repeat (9) step(1'b1, 1'b1, 1'b0, 0);
    chk("nine", 32'(bin_w), 32'd9);
    en = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bin",  32'(bin_w),  32'd0);
    chk("mid_rst_gray", 32'(gray_w), 32'd0);
    chk("mid_rst_wrap", 32'(wrap_w), 32'd0);
    chk("mid_rst_bin_s", 32'(bin_s), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cnt_w = 0; cnt_s = 0;
    step(1'b1, 1'b1, 1'b0, 0);
    chk("post_rst", 32'(bin_w), 32'd1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 4) != 0, $urandom % 2, ($urandom % 16) == 0, int'($urandom % 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish before bound");
    $fatal(1, "timeout");
  end

endmodule
